muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide execution unit, directly downstream of the register file. Consumes the two register read operands (read_data1/read_data2) and produces a 32-bit result for the write-back path into regfile write_data. The core stalls on busy and writes back on done. It covers MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU as one shift-add/shift-subtract engine, 1 bit per cycle.

---
 rtl/muldiv_unit.sv | 139 +++++++++++++
 tb/tb_muldiv_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit, one bit per cycle
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_next;

    logic [2:0]      op;
    logic            neg_q, neg_r;
    logic [XLEN-1:0] acc_hi, acc_lo, b_mag;
    logic [CW-1:0]   count;

    logic            is_div, a_signed, b_signed, a_neg, b_neg;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] a_abs, b_abs, special_res;

    assign is_div   = funct3[2];
    assign a_signed = is_div ? ~funct3[0] : (funct3 != 3'd3);
    assign b_signed = is_div ? ~funct3[0] : ~funct3[1];
    assign a_neg    = a_signed & op_a[XLEN-1];
    assign b_neg    = b_signed & op_b[XLEN-1];
    assign a_abs    = a_neg ? -op_a : op_a;
    assign b_abs    = b_neg ? -op_b : op_b;
    assign div_zero = is_div && (op_b == '0);
    assign div_ovf  = is_div && !funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    assign special  = div_zero | div_ovf;

    // Overflow case: quotient is op_a itself (most negative value), remainder zero
    always_comb begin
        special_res = '0;
        if (div_zero)
            special_res = funct3[1] ? op_a : '1;
        else if (div_ovf)
            special_res = funct3[1] ? '0 : op_a;
    end

    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [XLEN-1:0]   nxt_hi, nxt_lo, quo_s, rem_s, final_res;
    logic [2*XLEN-1:0] prod, prod_s;

    assign mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? b_mag : {XLEN{1'b0}})};
    assign div_shift = {acc_hi, acc_lo[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, b_mag};

    // Multiply: acc_lo holds the multiplier shifting out; divide: dividend shifting out, quotient in
    always_comb begin
        nxt_hi = mul_sum[XLEN:1];
        nxt_lo = {mul_sum[0], acc_lo[XLEN-1:1]};
        if (op[2]) begin
            nxt_hi = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
            nxt_lo = {acc_lo[XLEN-2:0], ~div_diff[XLEN]};
        end
    end

    assign prod   = {nxt_hi, nxt_lo};
    assign prod_s = neg_q ? -prod : prod;
    assign quo_s  = neg_q ? -nxt_lo : nxt_lo;
    assign rem_s  = neg_r ? -nxt_hi : nxt_hi;

    always_comb begin
        final_res = prod_s[2*XLEN-1:XLEN];
        case (op)
            3'd0:       final_res = prod_s[XLEN-1:0];
            3'd4, 3'd5: final_res = quo_s;
            3'd6, 3'd7: final_res = rem_s;
            default:    final_res = prod_s[2*XLEN-1:XLEN];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: if (start) state_next = special ? DONE : CALC;
            CALC: begin
                busy = 1'b1;
                if (count == CW'(XLEN-1)) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op     <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            acc_hi <= '0;
            acc_lo <= '0;
            b_mag  <= '0;
            count  <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    op     <= funct3;
                    neg_q  <= a_neg ^ b_neg;
                    neg_r  <= a_neg;
                    acc_hi <= '0;
                    acc_lo <= is_div ? a_abs : b_abs;
                    b_mag  <= is_div ? b_abs : a_abs;
                    count  <= '0;
                    if (special) result <= special_res;
                end
                CALC: begin
                    acc_hi <= nxt_hi;
                    acc_lo <= nxt_lo;
                    count  <= count + CW'(1);
                    if (count == CW'(XLEN-1)) result <= final_res;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        busy, done;
    logic [31:0] result;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, ub, p;
        longint unsigned up;
        int              ia, ib;
        logic [63:0]     pv;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        ia = $signed(a);
        ib = $signed(b);
        case (f)
            3'd0, 3'd1: begin p = sa * sb; pv = p; return (f == 3'd0) ? pv[31:0] : pv[63:32]; end
            3'd2: begin p = sa * ub; pv = p; return pv[63:32]; end
            3'd3: begin up = {32'b0, a} * {32'b0, b}; pv = up; return pv[63:32]; end
            default: begin
                if (b == 32'h0) return f[1] ? a : 32'hFFFF_FFFF;
                if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    return f[1] ? 32'h0 : 32'h8000_0000;
                case (f)
                    3'd4:    return ia / ib;
                    3'd5:    return a / b;
                    3'd6:    return ia % ib;
                    default: return a % b;
                endcase
            end
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && (b == 32'h0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0)
                check("spurious_done", 32'd1, 32'd0);
            else
                check("result", result, exp_q.pop_front());
        end
    end

    // Called right after the accepting edge; lat counts edges until done is seen
    task automatic wait_done(input int exp_lat, input logic [31:0] hold, input int poke_at);
        int lat = 0;
        int bcnt = 0;
        int hold_ok = 1;
        while (!done && lat < 200) begin
            bcnt += int'(busy);
            if (result !== hold) hold_ok = 0;
            if (lat == poke_at) begin
                start = 1'b1; funct3 = 3'd5; op_a = 32'd9; op_b = 32'd9;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check("latency", lat, exp_lat);
        check("busy_cycles", bcnt, exp_lat);
        check("result_hold", hold_ok, 1);
    endtask

    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input int poke_at);
        logic [31:0] hold;
        hold = result;
        funct3 = f; op_a = a; op_b = b; start = 1'b1;
        exp_q.push_back(model(f, a, b));
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(is_special(f, a, b) ? 0 : 32, hold, poke_at);
        @(posedge clk); #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] r1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", result, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(3'd0, 32'd7, 32'd6, -1);
        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2, -1);
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2, -1);
        do_op(3'd5, 32'd100, 32'd7, -1);
        do_op(3'd7, 32'd100, 32'd7, -1);
        do_op(3'd5, 32'hDEAD_BEEF, 32'd0, -1);
        do_op(3'd6, 32'h1234_5678, 32'd0, -1);
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        do_op(3'd1, 32'h8000_0000, 32'h8000_0000, -1);
        do_op(3'd4, 32'h8000_0000, 32'd3, -1);
        for (int i = 0; i < 10; i++)
            do_op(3'($urandom_range(0, 7)), $urandom, (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom, -1);

        // Restart request and operand changes mid-calculation are ignored
        do_op(3'd0, 32'd3, 32'd5, 5);

        // Back-to-back: start in DONE is ignored, start in following IDLE is accepted
        funct3 = 3'd5; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
        exp_q.push_back(model(3'd5, 32'd100, 32'd7));
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(32, result, -1);
        r1 = model(3'd5, 32'd100, 32'd7);
        funct3 = 3'd7; start = 1'b1;
        exp_q.push_back(model(3'd7, 32'd100, 32'd7));
        @(posedge clk); #1;
        check("b2b_done_start_ignored", 32'(busy), 32'd0);
        check("b2b_result_held", result, r1);
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_idle_start_accepted", 32'(busy), 32'd1);
        wait_done(32, r1, -1);
        @(posedge clk); #1;

        // Reset during CALC aborts with no done pulse
        funct3 = 3'd0; op_a = 32'd11; op_b = 32'd13; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", result, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("abort_idle_busy", 32'(busy), 32'd0);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
